// File: rtl/imm_encoder_pipe.sv
// Packs a 32-bit immediate into the immediate fields of a RISC-V instruction word.
// Two-stage valid/ready pipeline with a range check and saturating debug counters.
module imm_encoder_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_base_instr,
   input  logic [31:0]      in_imm,
   input  logic [2:0]       in_imm_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] pack_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [2:0] SRC_I = 3'b000;
   localparam logic [2:0] SRC_S = 3'b001;
   localparam logic [2:0] SRC_B = 3'b010;
   localparam logic [2:0] SRC_J = 3'b011;
   localparam logic [2:0] SRC_U = 3'b100;

   logic        s1_valid_q;
   logic [31:0] s1_base_q;
   logic [31:0] s1_imm_q;
   logic [2:0]  s1_src_q;

   logic        out_valid_q;
   logic [31:0] out_instr_q;
   logic        out_err_q;

   logic [CNT_W-1:0] pack_cnt_q, pack_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

   logic        s2_adv, s1_adv, fire;
   logic [31:0] pk_instr_d;
   logic        pk_err_d;
   logic        sx11_ok, sx12_ok, sx20_ok;

   assign s2_adv   = !out_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = !s1_valid_q | s2_adv;
   assign fire     = out_valid_q & out_ready;

   // Sign-extension checks: upper bits must be all copies of the top kept bit.
   assign sx11_ok = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
   assign sx12_ok = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
   assign sx20_ok = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

   always_comb begin
      pk_instr_d = s1_base_q;
      pk_err_d   = 1'b1;
      case (s1_src_q)
         SRC_I: begin
            pk_instr_d[31:20] = s1_imm_q[11:0];
            pk_err_d          = !sx11_ok;
         end
         SRC_S: begin
            pk_instr_d[31:25] = s1_imm_q[11:5];
            pk_instr_d[11:7]  = s1_imm_q[4:0];
            pk_err_d          = !sx11_ok;
         end
         SRC_B: begin
            pk_instr_d[31]    = s1_imm_q[12];
            pk_instr_d[30:25] = s1_imm_q[10:5];
            pk_instr_d[11:8]  = s1_imm_q[4:1];
            pk_instr_d[7]     = s1_imm_q[11];
            pk_err_d          = !sx12_ok | s1_imm_q[0];
         end
         SRC_J: begin
            pk_instr_d[31]    = s1_imm_q[20];
            pk_instr_d[30:21] = s1_imm_q[10:1];
            pk_instr_d[20]    = s1_imm_q[11];
            pk_instr_d[19:12] = s1_imm_q[19:12];
            pk_err_d          = !sx20_ok | s1_imm_q[0];
         end
         SRC_U: begin
            pk_instr_d[31:12] = s1_imm_q[31:12];
            pk_err_d          = |s1_imm_q[11:0];
         end
         default: pk_err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_base_q  <= '0;
         s1_imm_q   <= '0;
         s1_src_q   <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_base_q <= in_base_instr;
            s1_imm_q  <= in_imm;
            s1_src_q  <= in_imm_src;
         end
      end
   end

   // Output data only moves when S1 hands over, so it holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_err_q   <= 1'b0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_adv) begin
            out_instr_q <= pk_instr_d;
            out_err_q   <= pk_err_d;
         end
      end
   end

   always_comb begin
      pack_cnt_d = pack_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (clr_cnt) begin
         pack_cnt_d = '0;
         err_cnt_d  = '0;
      end else if (fire) begin
         if (!(&pack_cnt_q))             pack_cnt_d = pack_cnt_q + 1'b1;
         if (out_err_q && !(&err_cnt_q)) err_cnt_d  = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         pack_cnt_q <= pack_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign pack_cnt  = pack_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder_pipe.sv
// Bench for imm_encoder_pipe: queue-based reference model, immediate-generator
// round-trip decode, counter model, and directed literal vectors.
module tb_imm_encoder_pipe;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready;
   logic [31:0]      in_base_instr, in_imm;
   logic [2:0]       in_imm_src;
   logic             out_valid, out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic             clr_cnt;
   logic [CNT_W-1:0] pack_cnt, err_cnt;

   imm_encoder_pipe #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_base_instr(in_base_instr), .in_imm(in_imm), .in_imm_src(in_imm_src),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err),
      .clr_cnt(clr_cnt), .pack_cnt(pack_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [31:0] imm;
      logic [2:0]  src;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;
   int   n_acc = 0, n_dlv = 0;
   int   m_pack = 0, m_err = 0;
   logic        h_valid = 1'b0;
   logic [31:0] h_instr;
   logic        h_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Immediate generator: what a decoder recovers from an instruction word.
   function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] src);
      case (src)
         3'd0:    return {{20{i[31]}}, i[31:20]};
         3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd4:    return {i[31:12], 12'b0};
         default: return 32'hx;
      endcase
   endfunction

   // Reference: field placement plus representability as signed ranges.
   function automatic exp_t model(input logic [31:0] base, input logic [31:0] imm,
                                  input logic [2:0] src);
      exp_t e;
      int   s;
      s = $signed(imm);
      e.instr = base; e.err = 1'b1; e.imm = imm; e.src = src;
      case (src)
         3'd0: begin
            e.instr = {imm[11:0], base[19:0]};
            e.err   = !(s >= -2048 && s <= 2047);
         end
         3'd1: begin
            e.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            e.err   = !(s >= -2048 && s <= 2047);
         end
         3'd2: begin
            e.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            e.err   = !(s >= -4096 && s <= 4095 && (s % 2) == 0);
         end
         3'd3: begin
            e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            e.err   = !(s >= -(1 << 20) && s <= (1 << 20) - 1 && (s % 2) == 0);
         end
         3'd4: begin
            e.instr = {imm[31:12], base[11:0]};
            e.err   = (imm % 4096) != 0;
         end
         default: ;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         m_pack = 0; m_err = 0; h_valid = 1'b0;
         chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
         chk("pack_cnt", 32'(pack_cnt), 32'(m_pack));
         chk("err_cnt",  32'(err_cnt),  32'(m_err));
         if (h_valid) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_instr", out_instr, h_instr);
            chk("hold_err",   {31'b0, out_err}, {31'b0, h_err});
         end
         h_valid = out_valid && !out_ready;
         h_instr = out_instr; h_err = out_err;
         if (out_valid && out_ready) begin
            chk("out_has_expected", {31'b0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("out_instr", out_instr, e.instr);
               chk("out_err",   {31'b0, out_err}, {31'b0, e.err});
               if (!out_err && e.src <= 3'd4) chk("roundtrip", decode(out_instr, e.src), e.imm);
            end
            n_dlv++;
         end
         if (clr_cnt) begin
            m_pack = 0; m_err = 0;
         end else if (out_valid && out_ready) begin
            if (m_pack < CNT_MAX) m_pack++;
            if (out_err && m_err < CNT_MAX) m_err++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(in_base_instr, in_imm, in_imm_src));
            n_acc++;
         end
      end
   end

   // Single word through an empty pipe with out_ready high: checks 2-cycle latency.
   task automatic lit(input string nm, input logic [31:0] base, input logic [31:0] imm,
                      input logic [2:0] src, input logic [31:0] ei, input logic ee);
      @(posedge clk); #1;
      in_valid = 1'b1; in_base_instr = base; in_imm = imm; in_imm_src = src;
      @(negedge clk); chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); chk({nm, "_not_early"}, {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({nm, "_instr"}, out_instr, ei);
      chk({nm, "_err"},   {31'b0, out_err}, {31'b0, ee});
   endtask

   task automatic send(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] src);
      logic acc;
      int   n;
      in_valid = 1'b1; in_base_instr = base; in_imm = imm; in_imm_src = src;
      n = 0;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1; n++;
      end while (!acc && n < 50);
      if (!acc) chk("send_timeout", {31'b0, acc}, 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, a0, cyc, st;
      exp_t m;
      logic [31:0] x, imm;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      in_base_instr = '0; in_imm = '0; in_imm_src = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_err",   {31'b0, out_err}, 32'd0);
      chk("rst_pack_cnt",  32'(pack_cnt), 32'd0);
      chk("rst_err_cnt",   32'(err_cnt), 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1; rst_n = 1'b1;

      // Pin the model itself against hand-computed words.
      m = model(32'h00000013, 32'hFFFFF800, 3'd0); chk("model_I", m.instr, 32'h80000013);
      m = model(32'h00000063, 32'h00000FFE, 3'd2); chk("model_B", m.instr, 32'h7E000FE3);
      m = model(32'h00000063, 32'h00000FFF, 3'd2); chk("model_B_err", {31'b0, m.err}, 32'd1);

      lit("T1_I",     32'h00000013, 32'hFFFFF800, 3'd0, 32'h80000013, 1'b0);
      lit("T1_I_max", 32'h00000013, 32'h000007FF, 3'd0, 32'h7FF00013, 1'b0);
      lit("T1_I_ovf", 32'h00000013, 32'h00000800, 3'd0, 32'h80000013, 1'b1);
      lit("T2_B",     32'h00000063, 32'h00000FFE, 3'd2, 32'h7E000FE3, 1'b0);
      lit("T2_B_odd", 32'h00000063, 32'h00000FFF, 3'd2, 32'h7E000FE3, 1'b1);
      lit("T3_U",     32'h00000537, 32'h12345000, 3'd4, 32'h12345537, 1'b0);
      lit("T3_U_low", 32'h00000537, 32'h12345001, 3'd4, 32'h12345537, 1'b1);
      lit("T3_J",     32'h0000006F, 32'h00100000, 3'd3, 32'h8000006F, 1'b1);
      lit("T3_S",     32'h00002023, 32'hFFFFFFFC, 3'd1, 32'hFE002E23, 1'b0);
      lit("T3_bad",   32'h00000033, 32'h00000004, 3'd6, 32'h00000033, 1'b1);
      @(posedge clk); #1;

      // T4: backpressure with four queued words.
      d0 = n_dlv; out_ready = 1'b0;
      fork
         begin
            send(32'h00000013, 32'd1, 3'd0);
            send(32'h00000013, 32'd2, 3'd0);
            send(32'h00000013, 32'd3, 3'd0);
            send(32'h00000013, 32'd4, 3'd0);
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("T4_in_ready_full", {31'b0, in_ready}, 32'd0);
            chk("T4_out_valid",     {31'b0, out_valid}, 32'd1);
            chk("T4_head_word",     out_instr, 32'h00100013);
            @(posedge clk); #1; out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("T4_delivered", 32'(n_dlv - d0), 32'd4);
      chk("T4_drained",   32'(q.size()), 32'd0);

      // T5: saturating counters.
      @(posedge clk); #1; clr_cnt = 1'b1;
      @(posedge clk); #1; clr_cnt = 1'b0;
      for (int i = 0; i < 20; i++)
         send(32'h00000013, 32'(i), (i == 3 || i == 7 || i == 11) ? 3'd5 : 3'd0);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("T5_pack_sat", 32'(pack_cnt), 32'd15);
      chk("T5_err_cnt",  32'(err_cnt),  32'd3);
      lit("T5_word", 32'h00000013, 32'd5, 3'd0, 32'h00500013, 1'b0);
      clr_cnt = 1'b1;
      @(posedge clk); #1; clr_cnt = 1'b0;
      @(negedge clk);
      chk("T5_clr_pack", 32'(pack_cnt), 32'd0);
      chk("T5_clr_err",  32'(err_cnt),  32'd0);

      // T6: random stream with mid-stream async reset.
      a0 = n_acc; cyc = 0;
      while (n_acc - a0 < 10000 && cyc < 40000) begin
         @(posedge clk); #1; cyc++;
         x = $urandom;
         st = $urandom_range(0, 3);
         case (st)
            0: imm = x;
            1: imm = 32'($signed(x) >>> $urandom_range(19, 31));
            2: imm = 32'($signed(x) >>> $urandom_range(19, 31)) & 32'hFFFF_FFFE;
            default: imm = x & 32'hFFFF_F000;
         endcase
         in_valid      = $urandom_range(0, 3) != 0;
         out_ready     = $urandom_range(0, 3) != 0;
         in_base_instr = $urandom;
         in_imm        = imm;
         in_imm_src    = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         clr_cnt       = $urandom_range(0, 199) == 0;
         if (cyc == 5000) begin
            #1; rst_n = 1'b0; in_valid = 1'b0;
            #1;
            chk("T6_async_out_valid", {31'b0, out_valid}, 32'd0);
            chk("T6_async_in_ready",  {31'b0, in_ready}, 32'd1);
            chk("T6_async_pack_cnt",  32'(pack_cnt), 32'd0);
            @(negedge clk);
            @(posedge clk); #1; rst_n = 1'b1;
         end
      end
      chk("T6_accept_count", {31'b0, (n_acc - a0) >= 10000}, 32'd1);
      in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("T6_drained",   32'(q.size()), 32'd0);
      chk("T6_out_idle",  {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
